// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and word-memory signals of the load/store unit.
// slave = the load/store unit itself; master = pipeline plus data memory.
interface load_store_unit_if;
  logic        Start;
  logic [31:0] Endereco;
  logic [31:0] Write_Data;
  logic        Mem_Write;
  logic        Mem_Read;
  logic [2:0]  Funct3;
  logic [31:0] Mem_Endereco;
  logic [31:0] Mem_Write_Data;
  logic        Mem_Write_En;
  logic        Mem_Read_En;
  logic [31:0] Mem_Read_Data;
  logic [31:0] Load_Data;
  logic        Done;
  logic        Busy;
  logic        Desalinhado;
  logic        Erro;

  modport slave (
    input  Start, Endereco, Write_Data, Mem_Write, Mem_Read, Funct3, Mem_Read_Data,
    output Mem_Endereco, Mem_Write_Data, Mem_Write_En, Mem_Read_En,
           Load_Data, Done, Busy, Desalinhado, Erro
  );

  modport master (
    output Start, Endereco, Write_Data, Mem_Write, Mem_Read, Funct3, Mem_Read_Data,
    input  Mem_Endereco, Mem_Write_Data, Mem_Write_En, Mem_Read_En,
           Load_Data, Done, Busy, Desalinhado, Erro
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end over a word memory; sub-word stores use read-modify-write.
// Done: 2 cycles after Start on error/misalign, 3 for loads and SW, 4 for SB/SH; Busy stalls the pipeline.
module load_store_unit #(
  parameter int NUM_PALAVRAS = 55
) (
  input  logic               clk,
  input  logic               reset_n,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CHECK, LOAD, WRITE, RMW_READ, RMW_WRITE, DONE} state_e;

  localparam logic [29:0] NUM_W = 30'(NUM_PALAVRAS);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] load_q, load_d;
  logic        des_q, des_d;
  logic        err_q, err_d;

  logic        illegal, misaligned, out_of_range;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data, merge_data;

  always_comb begin
    illegal = (rd_q == wr_q);
    if (rd_q && !(f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) illegal = 1'b1;
    if (wr_q && !(f3_q inside {3'b000, 3'b001, 3'b010}))                illegal = 1'b1;
  end

  // Halfword codes (001/101) need addr[0]=0, word code needs both low bits clear.
  assign misaligned   = !illegal && (((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                                     ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)));
  assign out_of_range = (addr_q[31:2] >= NUM_W);

  always_comb begin
    byte_sel = bus.Mem_Read_Data[7:0];
    case (addr_q[1:0])
      2'd1:    byte_sel = bus.Mem_Read_Data[15:8];
      2'd2:    byte_sel = bus.Mem_Read_Data[23:16];
      2'd3:    byte_sel = bus.Mem_Read_Data[31:24];
      default: byte_sel = bus.Mem_Read_Data[7:0];
    endcase
    half_sel = addr_q[1] ? bus.Mem_Read_Data[31:16] : bus.Mem_Read_Data[15:0];

    case (f3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_data = {24'd0, byte_sel};
      3'b101:  ext_data = {16'd0, half_sel};
      default: ext_data = bus.Mem_Read_Data;
    endcase

    merge_data = bus.Mem_Read_Data;
    if (f3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_data[7:0]   = wdata_q[7:0];
        2'd1:    merge_data[15:8]  = wdata_q[7:0];
        2'd2:    merge_data[23:16] = wdata_q[7:0];
        default: merge_data[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_data[31:16] = wdata_q[15:0];
    end else begin
      merge_data[15:0]  = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    merged_d = merged_q;
    load_d   = load_q;
    des_d    = des_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (bus.Start) begin
        state_d = CHECK;
        addr_d  = bus.Endereco;
        wdata_d = bus.Write_Data;
        f3_d    = bus.Funct3;
        rd_d    = bus.Mem_Read;
        wr_d    = bus.Mem_Write;
        des_d   = 1'b0;
        err_d   = 1'b0;
      end
      CHECK: begin
        err_d = illegal || out_of_range;
        des_d = misaligned;
        if (illegal || out_of_range || misaligned) begin
          state_d = DONE;
          if (rd_q) load_d = '0;
        end else if (rd_q)               state_d = LOAD;
        else if (f3_q[1:0] == 2'b10)     state_d = WRITE;
        else                             state_d = RMW_READ;
      end
      LOAD: begin
        load_d  = ext_data;
        state_d = DONE;
      end
      WRITE:     state_d = DONE;
      RMW_READ: begin
        merged_d = merge_data;
        state_d  = RMW_WRITE;
      end
      RMW_WRITE: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      merged_q <= '0;
      load_q   <= '0;
      des_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      merged_q <= merged_d;
      load_q   <= load_d;
      des_q    <= des_d;
      err_q    <= err_d;
    end
  end

  // Strobes are gated by reset_n so a reset landing in a write cycle never commits.
  assign bus.Mem_Write_En   = reset_n && ((state_q == WRITE) || (state_q == RMW_WRITE));
  assign bus.Mem_Read_En    = reset_n && ((state_q == LOAD) || (state_q == RMW_READ));
  assign bus.Mem_Endereco   = {2'b00, addr_q[31:2]};
  assign bus.Mem_Write_Data = (state_q == RMW_WRITE) ? merged_q : wdata_q;
  assign bus.Load_Data      = load_q;
  assign bus.Done           = (state_q == DONE);
  assign bus.Busy           = (state_q != IDLE);
  assign bus.Desalinhado    = des_q;
  assign bus.Erro           = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 55-word behavioural data memory.
module tb_load_store_unit;
  logic clk;
  logic reset_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [31:0] mem [0:54];

  load_store_unit_if bus();

  load_store_unit #(.NUM_PALAVRAS(55)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.Mem_Read_Data = (bus.Mem_Endereco < 32'd55) ? mem[bus.Mem_Endereco[5:0]] : 32'd0;

  always @(posedge clk)
    if (bus.Mem_Write_En && bus.Mem_Endereco < 32'd55)
      mem[bus.Mem_Endereco[5:0]] <= bus.Mem_Write_Data;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to Done; we end up in the IDLE cycle after DONE.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int done_cyc, output bit wen_seen,
                        output logic [31:0] ld, output logic des, output logic err);
    @(negedge clk);
    bus.Start = 1'b1; bus.Mem_Read = rd; bus.Mem_Write = wr;
    bus.Funct3 = f3; bus.Endereco = addr; bus.Write_Data = wdata;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    done_cyc = -1; wen_seen = 1'b0; ld = 'x; des = 1'bx; err = 1'bx;
    for (int c = 1; c < 10; c++) begin
      if (bus.Mem_Write_En) wen_seen = 1'b1;
      if (bus.Done) begin
        done_cyc = c; ld = bus.Load_Data; des = bus.Desalinhado; err = bus.Erro;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  int          dc, d1, d2, n_done, n_ren;
  bit          ws;
  logic [31:0] ld;
  logic        des, err;

  initial begin
    for (int i = 0; i < 55; i++) mem[i] = 32'd0;
    mem[5] = 32'h8899AABB;
    reset_n = 1'b0;
    bus.Start = 0; bus.Mem_Read = 0; bus.Mem_Write = 0;
    bus.Funct3 = 0; bus.Endereco = 0; bus.Write_Data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_data", bus.Load_Data, 32'd0);
    chk("rst_done", {31'd0, bus.Done}, 32'd0);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_flags", {30'd0, bus.Desalinhado, bus.Erro}, 32'd0);
    chk("rst_strobes", {30'd0, bus.Mem_Write_En, bus.Mem_Read_En}, 32'd0);
    chk("rst_mem_addr", bus.Mem_Endereco, 32'd0);
    chk("rst_mem_wdata", bus.Mem_Write_Data, 32'd0);
    reset_n = 1'b1;

    do_req(1, 0, 3'b000, 32'h15, 0, dc, ws, ld, des, err);
    chk("lb_data", ld, 32'hFFFFFFAA);
    chk("lb_done_cyc", dc, 3);
    do_req(1, 0, 3'b100, 32'h15, 0, dc, ws, ld, des, err);
    chk("lbu_data", ld, 32'h000000AA);
    chk("lbu_done_cyc", dc, 3);
    do_req(1, 0, 3'b001, 32'h16, 0, dc, ws, ld, des, err);
    chk("lh_data", ld, 32'hFFFF8899);
    do_req(1, 0, 3'b101, 32'h14, 0, dc, ws, ld, des, err);
    chk("lhu_data", ld, 32'h0000AABB);
    do_req(1, 0, 3'b010, 32'h14, 0, dc, ws, ld, des, err);
    chk("lw_data", ld, 32'h8899AABB);
    chk("lw_done_cyc", dc, 3);
    chk("lw_flags", {30'd0, des, err}, 32'd0);
    chk("busy_after_done", {31'd0, bus.Busy}, 32'd0);
    chk("load_data_hold", bus.Load_Data, 32'h8899AABB);

    do_req(0, 1, 3'b000, 32'h14, 32'h123456CC, dc, ws, ld, des, err);
    chk("sb_mem", mem[5], 32'h8899AACC);
    chk("sb_done_cyc", dc, 4);
    chk("sb_wen_seen", {31'd0, ws}, 32'd1);
    do_req(0, 1, 3'b001, 32'h16, 32'h0000BEEF, dc, ws, ld, des, err);
    chk("sh_mem", mem[5], 32'hBEEFAACC);
    chk("sh_done_cyc", dc, 4);
    do_req(0, 1, 3'b010, 32'h0, 32'hDEADBEEF, dc, ws, ld, des, err);
    chk("sw_mem", mem[0], 32'hDEADBEEF);
    chk("sw_done_cyc", dc, 3);
    do_req(1, 0, 3'b010, 32'h0, 0, dc, ws, ld, des, err);
    chk("lw_after_sw", ld, 32'hDEADBEEF);

    do_req(0, 1, 3'b001, 32'h17, 32'h00001111, dc, ws, ld, des, err);
    chk("mis_sh_flags", {30'd0, des, err}, 32'h2);
    chk("mis_sh_done_cyc", dc, 2);
    chk("mis_sh_no_wen", {31'd0, ws}, 32'd0);
    chk("mis_sh_mem", mem[5], 32'hBEEFAACC);

    do_req(1, 0, 3'b010, 32'hDC, 0, dc, ws, ld, des, err);
    chk("oor_flags", {30'd0, des, err}, 32'h1);
    chk("oor_load_data", ld, 32'd0);
    chk("oor_done_cyc", dc, 2);
    do_req(1, 0, 3'b010, 32'hDD, 0, dc, ws, ld, des, err);
    chk("oor_mis_flags", {30'd0, des, err}, 32'h3);
    do_req(1, 0, 3'b011, 32'h14, 0, dc, ws, ld, des, err);
    chk("bad_f3_flags", {30'd0, des, err}, 32'h1);
    do_req(1, 1, 3'b010, 32'h14, 0, dc, ws, ld, des, err);
    chk("rd_wr_flags", {30'd0, des, err}, 32'h1);
    chk("rd_wr_no_wen", {31'd0, ws}, 32'd0);
    do_req(0, 0, 3'b010, 32'h14, 0, dc, ws, ld, des, err);
    chk("no_op_flags", {30'd0, des, err}, 32'h1);
    do_req(1, 0, 3'b010, 32'h14, 0, dc, ws, ld, des, err);
    chk("flags_cleared", {30'd0, des, err}, 32'd0);
    chk("lw_after_err", ld, 32'hBEEFAACC);

    // Restore word 5, then reset an SB in its RMW_WRITE cycle.
    do_req(0, 1, 3'b010, 32'h14, 32'h8899AABB, dc, ws, ld, des, err);
    chk("restore_mem", mem[5], 32'h8899AABB);
    @(negedge clk);
    bus.Start = 1; bus.Mem_Read = 0; bus.Mem_Write = 1;
    bus.Funct3 = 3'b000; bus.Endereco = 32'h14; bus.Write_Data = 32'h000000EE;
    @(posedge clk); #1;
    bus.Start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_wr_strobe_gated", {31'd0, bus.Mem_Write_En}, 32'd0);
    @(posedge clk); #1;
    chk("rst_wr_mem", mem[5], 32'h8899AABB);
    chk("rst_wr_done", {31'd0, bus.Done}, 32'd0);
    chk("rst_wr_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_wr_outputs", bus.Load_Data | bus.Mem_Endereco | bus.Mem_Write_Data, 32'd0);
    chk("rst_wr_bits", {28'd0, bus.Desalinhado, bus.Erro, bus.Mem_Write_En, bus.Mem_Read_En}, 32'd0);
    reset_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.Done) n_done++;
    end
    chk("rst_wr_no_late_done", n_done, 0);

    // Start held high across a busy LW and its DONE cycle.
    @(negedge clk);
    bus.Start = 1; bus.Mem_Read = 1; bus.Mem_Write = 0;
    bus.Funct3 = 3'b010; bus.Endereco = 32'h14;
    @(posedge clk); #1;
    d1 = -1; d2 = -1; n_done = 0; n_ren = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 5) bus.Start = 0;
      if (c == 4) chk("hold_busy_c4", {31'd0, bus.Busy}, 32'd0);
      if (bus.Mem_Read_En) n_ren++;
      if (bus.Done) begin
        n_done++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
      @(posedge clk); #1;
    end
    chk("hold_done_count", n_done, 2);
    chk("hold_read_count", n_ren, 2);
    chk("hold_first_done", d1, 3);
    chk("hold_second_done", d2, 7);
    chk("hold_load_data", bus.Load_Data, 32'h8899AABB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end placed between the execute stage (ALU address plus rs2 data) and the word-organised data memory. It converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word memory accesses. Sub-word stores are done as a two-cycle read-modify-write, and load results are extracted and extended for writeback. The block also checks alignment and memory range, and it stalls the pipeline through `Busy` while an access is in flight.

## Interface
- `NUM_PALAVRAS`, 55: number of words in the data memory; legal word indices are 0..NUM_PALAVRAS-1.
- `clk` input 1: single clock; all state changes on posedge.
- `reset_n` input 1: synchronous, active-low reset.
- `Start` input 1: request valid; sampled only in IDLE.
- `Endereco` input 32: byte address from the ALU.
- `Write_Data` input 32: store data (rs2).
- `Mem_Write` input 1: request is a store.
- `Mem_Read` input 1: request is a load.
- `Funct3` input 3: access size and signedness.
- `Mem_Endereco` output 32: word index to memory = `{2'b0, addr_q[31:2]}`.
- `Mem_Write_Data` output 32: full word to memory.
- `Mem_Write_En` output 1: memory write strobe; memory commits on posedge.
- `Mem_Read_En` output 1: memory read enable.
- `Mem_Read_Data` input 32: combinational read data from memory.
- `Load_Data` output 32: extended load result.
- `Done` output 1: one-cycle completion pulse.
- `Busy` output 1: high whenever state ≠ IDLE.
- `Desalinhado` output 1: misaligned access flag, valid with `Done`.
- `Erro` output 1: illegal request or out-of-range flag, valid with `Done`.

## Operation
- **Request latch.** On `Start` in IDLE, latch `Endereco`, `Write_Data`, `Funct3` and the operation. `Start` is ignored in every other state.
- **Load funct3 codes.** 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- **Store funct3 codes.** 000 SB, 001 SH, 010 SW.
- **Illegal requests → `Erro`, no memory access:**
  - any other funct3 code;
  - `Mem_Read` and `Mem_Write` both high;
  - both low.
- **Misalignment → `Desalinhado`, no memory access:**
  - LH, LHU or SH with addr[0] = 1;
  - LW or SW with addr[1:0] ≠ 0.
- **Range check.** A word index ≥ NUM_PALAVRAS sets `Erro` and performs no access. If misaligned and out of range together, both flags are set.
- **Byte lanes.** Little-endian; lane k = addr[1:0] selects bits [8k+7:8k]. A halfword uses lanes {addr[1], 0} and {addr[1], 1}, i.e. bits [16·addr[1]+15 : 16·addr[1]].
- **Load extension.** LB and LH sign-extend; LBU and LHU zero-extend.
- **SB/SH merge.** Read the old word, replace the addressed lane(s) with the low byte or halfword of `Write_Data`, then write the merged word back.
- **FSM states:**
  - IDLE: on `Start`, go to CHECK.
  - CHECK: if error or misaligned, go to DONE. Otherwise a load goes to LOAD, SW goes to WRITE, and SB/SH go to RMW_READ.
  - LOAD: `Mem_Read_En` = 1. Capture the extended `Mem_Read_Data` into `Load_Data`, then go to DONE.
  - WRITE: `Mem_Write_En` = 1 with `Mem_Write_Data` = `Write_Data`, then go to DONE.
  - RMW_READ: `Mem_Read_En` = 1. Register the merged word, then go to RMW_WRITE.
  - RMW_WRITE: `Mem_Write_En` = 1 with the merged word, then go to DONE.
  - DONE: `Done` = 1 for one cycle, then go to IDLE.
- **Strobe qualification.** `Mem_Write_En` and `Mem_Read_En` are decoded from the state register AND `reset_n`. A reset asserted in RMW_WRITE or WRITE therefore commits no write.
- **`Load_Data` hold.** `Load_Data` holds its value until the next successful load. On an erroring or misaligned load it is set to 0.
- **Flag hold.** `Desalinhado` and `Erro` are registered in CHECK and cleared on the next accepted `Start`.

## Timing
- **Reset.** State goes to IDLE. `Load_Data`, `Done`, `Busy`, `Desalinhado`, `Erro`, `Mem_Write_En`, `Mem_Read_En`, `Mem_Endereco` and `Mem_Write_Data` are all 0. Reset in any state aborts the access with no write and no `Done`.
- **Cycle numbering.** Cycle 0 is the `Start` edge. `Busy` rises after edge 0 and falls after the DONE cycle.
- **`Done` latency per request type:**

| Request | `Done` high in cycle | Write commits at end of cycle |
|---|---|---|
| Error or misaligned | 2 | none |
| Load, SW | 3 | 2 (SW only) |
| SB, SH | 4 | 3 |

- **Back-to-back requests.** The earliest next accepted `Start` is the cycle after DONE. `Start` during DONE is ignored, so the upstream holds it until `Busy` = 0.
- **Read path.** `Mem_Read_Data` is sampled at the end of LOAD or RMW_READ. The memory read path is combinational, so no wait state is needed.

## Test plan
Setup for every scenario: memory word 5 = 0x8899AABB, all other words 0.

- **Load extension.** LB at 0x15 → `Load_Data` = 0xFFFFFFAA. LBU at 0x15 → 0x000000AA. LH at 0x16 → 0xFFFF8899. LW at 0x14 → 0x8899AABB. `Done` is high in cycle 3 each time.
- **Sub-word stores (RMW).**
  - SB at 0x14 with data 0x123456CC → word 5 = 0x8899AACC; `Done` in cycle 4.
  - Then SH at 0x16 with data 0x0000BEEF → word 5 = 0xBEEFAACC.
- **Misaligned store.** SH at 0x17 → `Desalinhado` = 1, `Done` in cycle 2, `Mem_Write_En` never high, word 5 unchanged.
- **Out of range and illegal requests.**
  - LW at 0xDC (index 55) → `Erro` = 1, `Load_Data` = 0.
  - Funct3 = 011 on a load → `Erro` = 1.
  - `Mem_Read` = `Mem_Write` = 1 → `Erro` = 1.
- **Reset during write.** SB at 0x14, with `reset_n` driven low in the RMW_WRITE cycle → word 5 stays 0x8899AABB, no `Done`, all outputs 0 next cycle.
- **Start while busy.** `Start` held high through a busy LW and its DONE cycle → exactly one access per accepted `Start`; a second LW is accepted only after `Busy` = 0.
